// File: rtl/legv8_seq_control_unit.sv
// Multi-cycle LEGv8 control unit: latches one instruction per handshake and
// sequences it through EXEC / MOVK2 / MEM_WAIT, emitting the control word and
// literal each cycle. Illegal opcodes and memory timeouts park it in FAULT.
// DATA_W must be at least 64 so every MOVZ/MOVK halfword position fits.
module legv8_seq_control_unit #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [31:0]       i_instr,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [4:0]        i_status,
    input  logic              i_mem_ready,
    output logic [30:0]       o_cw,
    output logic [DATA_W-1:0] o_k,
    output logic              o_busy,
    output logic              o_fault
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    // ALU function select: [4:2] operation, [0] invert B with carry-in
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REG  = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MOVK2,
        S_MEM_WAIT,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_ir;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ready;
    logic              r_busy;
    logic              r_fault;

    logic [4:0]        w_da, w_sa, w_sb, w_fs;
    logic              w_bsel, w_asel, w_rw, w_mw, w_sl;
    logic              w_enb, w_enalu, w_enmem, w_enpc;
    logic [1:0]        w_ps;
    logic [DATA_W-1:0] w_k;
    logic              w_illegal;
    logic              w_mem_word;

    logic [4:0]        w_rd, w_rn, w_rm;
    logic [5:0]        w_hw_shift;
    logic              w_is_d;

    assign w_rd       = r_ir[4:0];
    assign w_rn       = r_ir[9:5];
    assign w_rm       = r_ir[20:16];
    assign w_hw_shift = {r_ir[22:21], 4'b0000};
    assign w_is_d     = (r_ir[31:23] == 9'b111110000) && !r_ir[21];

    // Condition evaluation for B.cond; flags = {V,C,N,Z}
    function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
        logic v, cf, n, z, r;
        v  = f[3];
        cf = f[2];
        n  = f[1];
        z  = f[0];
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cf;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cf & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'd7)) begin
            r = ~r;
        end
        return r;
    endfunction

    // State, IR, wait counter and status flags
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_ir    <= 32'd0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == S_IDLE) && i_instr_valid) begin
                r_ir <= i_instr;
            end
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_fault <= (w_state_nxt == S_FAULT);
        end
    end

    // Next-state and control-word decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_da        = 5'd0;
        w_sa        = 5'd0;
        w_sb        = 5'd0;
        w_fs        = FS_AND;
        w_bsel      = 1'b0;
        w_asel      = 1'b0;
        w_rw        = 1'b0;
        w_mw        = 1'b0;
        w_sl        = 1'b0;
        w_enb       = 1'b0;
        w_enalu     = 1'b0;
        w_enmem     = 1'b0;
        w_enpc      = 1'b0;
        w_ps        = PS_HOLD;
        w_k         = '0;
        w_illegal   = 1'b0;
        w_mem_word  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_instr_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                w_state_nxt = S_IDLE;
                if (!r_ir[26]) begin
                    case (r_ir[25:23])
                        3'd0: begin
                            if (w_is_d) begin
                                w_mem_word = 1'b1;
                                if (i_mem_ready) begin
                                    w_rw = r_ir[22];
                                    w_ps = PS_INC;
                                end else begin
                                    w_state_nxt = S_MEM_WAIT;
                                    w_cnt_nxt   = CNT_W'(1);
                                end
                            end else begin
                                w_illegal = 1'b1;
                            end
                        end
                        3'd2: begin
                            w_da    = w_rd;
                            w_sa    = w_rn;
                            w_fs    = r_ir[30] ? FS_SUB : FS_ADD;
                            w_bsel  = 1'b1;
                            w_k     = DATA_W'(r_ir[21:10]);
                            w_sl    = r_ir[29];
                            w_rw    = 1'b1;
                            w_enalu = 1'b1;
                            w_ps    = PS_INC;
                        end
                        3'd4: begin
                            w_da    = w_rd;
                            w_sa    = w_rn;
                            case (r_ir[30:29])
                                2'b01:   w_fs = FS_OR;
                                2'b10:   w_fs = FS_XOR;
                                default: w_fs = FS_AND;
                            endcase
                            w_bsel  = 1'b1;
                            w_k     = DATA_W'(r_ir[21:10]);
                            w_sl    = &r_ir[30:29];
                            w_rw    = 1'b1;
                            w_enalu = 1'b1;
                            w_ps    = PS_INC;
                        end
                        3'd5: begin
                            w_da    = w_rd;
                            w_bsel  = 1'b1;
                            w_rw    = 1'b1;
                            w_enalu = 1'b1;
                            if (r_ir[29]) begin
                                // MOVK step 1: clear the target halfword
                                w_sa        = w_rd;
                                w_fs        = FS_AND;
                                w_k         = ~(DATA_W'(16'hFFFF) << w_hw_shift);
                                w_state_nxt = S_MOVK2;
                            end else begin
                                w_sa = 5'd31;
                                w_fs = FS_OR;
                                w_k  = DATA_W'(r_ir[20:5]) << w_hw_shift;
                                w_ps = PS_INC;
                            end
                        end
                        3'd6: begin
                            w_da    = w_rd;
                            w_sa    = w_rn;
                            w_rw    = 1'b1;
                            w_enalu = 1'b1;
                            w_ps    = PS_INC;
                            if (r_ir[28]) begin
                                w_fs   = r_ir[21] ? FS_LSL : FS_LSR;
                                w_bsel = 1'b1;
                                w_k    = DATA_W'(r_ir[15:10]);
                            end else begin
                                w_sb = w_rm;
                                w_fs = r_ir[30] ? FS_SUB : FS_ADD;
                                w_sl = r_ir[29];
                            end
                        end
                        default: w_illegal = 1'b1;
                    endcase
                end else begin
                    case (r_ir[31:29])
                        3'd0: begin
                            w_k  = DATA_W'($signed(r_ir[25:0]));
                            w_ps = PS_REL;
                        end
                        3'd2: begin
                            w_k  = DATA_W'($signed(r_ir[23:5]));
                            w_ps = {cond_met(r_ir[3:0], i_status[4:1]), 1'b1};
                        end
                        3'd4: begin
                            w_da   = 5'd30;
                            w_rw   = 1'b1;
                            w_enpc = 1'b1;
                            w_k    = DATA_W'($signed(r_ir[25:0]));
                            w_ps   = PS_REL;
                        end
                        3'd5: begin
                            w_sa = 5'd31;
                            w_sb = w_rd;
                            w_fs = FS_OR;
                            w_k  = DATA_W'($signed(r_ir[23:5]));
                            w_ps = {r_ir[24] ^ i_status[0], 1'b1};
                        end
                        3'd6: begin
                            w_sa = w_rn;
                            w_ps = PS_REG;
                        end
                        default: w_illegal = 1'b1;
                    endcase
                end
                if (w_illegal) begin
                    w_state_nxt = S_FAULT;
                end
            end

            S_MOVK2: begin
                w_da        = w_rd;
                w_sa        = w_rd;
                w_fs        = FS_OR;
                w_bsel      = 1'b1;
                w_k         = DATA_W'(r_ir[20:5]) << w_hw_shift;
                w_rw        = 1'b1;
                w_enalu     = 1'b1;
                w_ps        = PS_INC;
                w_state_nxt = S_IDLE;
            end

            S_MEM_WAIT: begin
                w_mem_word = 1'b1;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (i_mem_ready) begin
                    w_rw        = r_ir[22];
                    w_ps        = PS_INC;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt = S_FAULT;
                end
            end

            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Address/data fields shared by the EXEC and MEM_WAIT memory words
        if (w_mem_word) begin
            w_sa   = w_rn;
            w_fs   = FS_ADD;
            w_bsel = 1'b1;
            w_k    = DATA_W'($signed(r_ir[20:12]));
            if (r_ir[22]) begin
                w_da    = w_rd;
                w_enmem = 1'b1;
            end else begin
                w_sb  = w_rd;
                w_mw  = 1'b1;
                w_enb = 1'b1;
            end
        end
    end

    assign o_cw = {w_da, w_sa, w_sb, w_fs, w_bsel, w_asel, w_rw, w_mw, w_sl,
                   w_enb, w_enalu, w_enmem, w_enpc, w_ps};
    assign o_k           = w_k;
    assign o_instr_ready = r_ready;
    assign o_busy        = r_busy;
    // Illegal opcode is flagged in its own EXEC cycle, then held by FAULT
    assign o_fault       = r_fault | w_illegal;

endmodule

// File: tb/tb_legv8_seq_control_unit.sv
// Scoreboard bench for legv8_seq_control_unit: each task drives one scenario,
// queues the expected per-cycle outputs and compares them as the DUT emits them.
module tb_legv8_seq_control_unit;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid;
    logic        ready;
    logic [4:0]  status;
    logic        mem_ready;
    logic [30:0] cw;
    logic [63:0] k;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    legv8_seq_control_unit #(.DATA_W(64), .MEM_TIMEOUT(TO)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_instr      (instr),
        .i_instr_valid(valid),
        .o_instr_ready(ready),
        .i_status     (status),
        .i_mem_ready  (mem_ready),
        .o_cw         (cw),
        .o_k          (k),
        .o_busy       (busy),
        .o_fault      (fault)
    );

    typedef struct {
        string       name;
        logic [30:0] cw;
        logic [63:0] k;
        logic        rdy;
        logic        busy;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] I_MOVK  = 32'hF2D7DDE3;
    localparam logic [31:0] I_LDUR  = 32'hF8408041;
    localparam logic [31:0] I_STUR  = 32'hF8008041;
    localparam logic [31:0] I_BEQ   = 32'h54000080;
    localparam logic [31:0] I_CBNZ  = 32'hB5000085;
    localparam logic [31:0] I_CBZ   = 32'hB4000085;
    localparam logic [31:0] I_MOVZ  = 32'hD2A24687;
    localparam logic [31:0] I_ADDI  = 32'h91001441;

    // flags = {Bsel,Asel,RegWrite,mem_write,status_load,En_B,En_Alu,En_mem,En_PC}
    function automatic logic [30:0] mk_cw(input logic [4:0] da, input logic [4:0] sa,
                                          input logic [4:0] sbr, input logic [4:0] fs,
                                          input logic [8:0] flags, input logic [1:0] ps);
        return {da, sa, sbr, fs, flags, ps};
    endfunction

    function automatic exp_t e_idle(input string nm);
        return '{nm, 31'd0, 64'd0, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic exp_t e_word(input string nm, input logic [30:0] c, input logic [63:0] kk);
        return '{nm, c, kk, 1'b0, 1'b1, 1'b0};
    endfunction

    function automatic exp_t e_fault(input string nm);
        return '{nm, 31'd0, 64'd0, 1'b0, 1'b1, 1'b1};
    endfunction

    // Apply one cycle of inputs just after the active edge
    task automatic drive(input logic r, input logic [31:0] ins, input logic v,
                         input logic [4:0] st, input logic mr);
        @(posedge clk);
        #1;
        rst       = r;
        instr     = ins;
        valid     = v;
        status    = st;
        mem_ready = mr;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int n = 0; n < 2; n++) begin
            drive(n == 0, 32'd0, 1'b0, 5'd0, 1'b0);
            sb.push_back(e_idle("reset"));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_illegal;
        exp_t e;
        for (int n = 0; n < 6; n++) begin
            case (n)
                0: begin drive(0, 32'd0, 1, 5'd0, 0);  sb.push_back(e_idle("illegal_accept")); end
                1: begin drive(0, 32'd0, 0, 5'd0, 0);  sb.push_back(e_fault("illegal_exec")); end
                2: begin drive(0, 32'd0, 0, 5'd0, 0);  sb.push_back(e_fault("illegal_sticky")); end
                3: begin drive(0, I_MOVZ, 1, 5'd0, 1); sb.push_back(e_fault("illegal_ignore")); end
                4: begin drive(1, 32'd0, 0, 5'd0, 0);  sb.push_back(e_fault("illegal_rst_pending")); end
                default: begin drive(0, 32'd0, 0, 5'd0, 0); sb.push_back(e_idle("illegal_rst_exit")); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_movk;
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            case (n)
                0: begin drive(0, I_MOVK, 1, 5'd0, 0); sb.push_back(e_idle("movk_accept")); end
                1: begin
                    drive(0, 32'd0, 0, 5'd0, 0);
                    sb.push_back(e_word("movk_exec", mk_cw(5'd3, 5'd3, 5'd0, 5'b00000, 9'b101000100, 2'b00),
                                        64'hFFFF0000FFFFFFFF));
                end
                2: begin
                    drive(0, 32'd0, 0, 5'd0, 0);
                    sb.push_back(e_word("movk_2", mk_cw(5'd3, 5'd3, 5'd0, 5'b00100, 9'b101000100, 2'b01),
                                        64'h0000BEEF00000000));
                end
                default: begin drive(0, 32'd0, 0, 5'd0, 0); sb.push_back(e_idle("movk_done")); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_ldur_wait;
        exp_t e;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                drive(0, I_LDUR, 1, 5'd0, 0);
                sb.push_back(e_idle("ldur_accept"));
            end else if (n <= 3) begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_word("ldur_stall", mk_cw(5'd1, 5'd2, 5'd0, 5'b01000, 9'b100000010, 2'b00), 64'd8));
            end else if (n == 4) begin
                drive(0, 32'd0, 0, 5'd0, 1);
                sb.push_back(e_word("ldur_done", mk_cw(5'd1, 5'd2, 5'd0, 5'b01000, 9'b101000010, 2'b01), 64'd8));
            end else begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_idle("ldur_idle"));
            end
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_stur_timeout;
        exp_t e;
        for (int n = 0; n < 20; n++) begin
            if (n == 0) begin
                drive(0, I_STUR, 1, 5'd0, 0);
                sb.push_back(e_idle("stur_to_accept"));
            end else if (n <= 16) begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_word("stur_to_stall", mk_cw(5'd0, 5'd2, 5'd1, 5'b01000, 9'b100101000, 2'b00), 64'd8));
            end else if (n == 17) begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_fault("stur_to_fault"));
            end else if (n == 18) begin
                drive(1, 32'd0, 0, 5'd0, 1);
                sb.push_back(e_fault("stur_to_hold"));
            end else begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_idle("stur_to_reset"));
            end
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_stur_last_wait;
        exp_t e;
        for (int n = 0; n < 18; n++) begin
            if (n == 0) begin
                drive(0, I_STUR, 1, 5'd0, 0);
                sb.push_back(e_idle("stur_last_accept"));
            end else if (n <= 15) begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_word("stur_last_stall", mk_cw(5'd0, 5'd2, 5'd1, 5'b01000, 9'b100101000, 2'b00), 64'd8));
            end else if (n == 16) begin
                drive(0, 32'd0, 0, 5'd0, 1);
                sb.push_back(e_word("stur_last_done", mk_cw(5'd0, 5'd2, 5'd1, 5'b01000, 9'b100101000, 2'b01), 64'd8));
            end else begin
                drive(0, 32'd0, 0, 5'd0, 0);
                sb.push_back(e_idle("stur_last_idle"));
            end
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_branch;
        exp_t e;
        logic [30:0] cb_cw;
        for (int n = 0; n < 9; n++) begin
            case (n)
                0: begin drive(0, I_BEQ, 1, 5'd0, 0);     sb.push_back(e_idle("beq_accept")); end
                1: begin drive(0, 32'd0, 0, 5'b00010, 0); sb.push_back(e_word("beq_taken", 31'd3, 64'd4)); end
                2: begin drive(0, I_BEQ, 1, 5'd0, 0);     sb.push_back(e_idle("beq_accept2")); end
                3: begin drive(0, 32'd0, 0, 5'b11100, 0); sb.push_back(e_word("beq_not_taken", 31'd1, 64'd4)); end
                4: begin drive(0, I_CBNZ, 1, 5'd0, 0);    sb.push_back(e_idle("cbnz_accept")); end
                5: begin
                    drive(0, 32'd0, 0, 5'b11110, 0);
                    cb_cw = mk_cw(5'd0, 5'd31, 5'd5, 5'b00100, 9'd0, 2'b11);
                    sb.push_back(e_word("cbnz_taken", cb_cw, 64'd4));
                end
                6: begin drive(0, I_CBZ, 1, 5'd0, 0);     sb.push_back(e_idle("cbz_accept")); end
                7: begin
                    drive(0, 32'd0, 0, 5'd0, 0);
                    cb_cw = mk_cw(5'd0, 5'd31, 5'd5, 5'b00100, 9'd0, 2'b01);
                    sb.push_back(e_word("cbz_not_taken", cb_cw, 64'd4));
                end
                default: begin drive(0, 32'd0, 0, 5'd0, 0); sb.push_back(e_idle("branch_idle")); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_reset_in_movk2;
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            case (n)
                0: begin drive(0, I_MOVK, 1, 5'd0, 0); sb.push_back(e_idle("rmovk_accept")); end
                1: begin
                    drive(0, 32'd0, 0, 5'd0, 0);
                    sb.push_back(e_word("rmovk_exec", mk_cw(5'd3, 5'd3, 5'd0, 5'b00000, 9'b101000100, 2'b00),
                                        64'hFFFF0000FFFFFFFF));
                end
                2: begin
                    drive(1, 32'd0, 0, 5'd0, 0);
                    sb.push_back(e_word("rmovk_2", mk_cw(5'd3, 5'd3, 5'd0, 5'b00100, 9'b101000100, 2'b01),
                                        64'h0000BEEF00000000));
                end
                default: begin drive(0, 32'd0, 0, 5'd0, 0); sb.push_back(e_idle("rmovk_idle")); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        for (int n = 0; n < 5; n++) begin
            case (n)
                0: begin drive(0, I_MOVZ, 1, 5'd0, 0); sb.push_back(e_idle("b2b_accept_movz")); end
                1: begin
                    drive(0, I_ADDI, 1, 5'd0, 0);
                    sb.push_back(e_word("b2b_movz", mk_cw(5'd7, 5'd31, 5'd0, 5'b00100, 9'b101000100, 2'b01),
                                        64'h0000000012340000));
                end
                2: begin drive(0, I_ADDI, 1, 5'd0, 0); sb.push_back(e_idle("b2b_accept_addi")); end
                3: begin
                    drive(0, 32'd0, 0, 5'd0, 0);
                    sb.push_back(e_word("b2b_addi", mk_cw(5'd1, 5'd2, 5'd0, 5'b01000, 9'b101000100, 2'b01), 64'd5));
                end
                default: begin drive(0, 32'd0, 0, 5'd0, 0); sb.push_back(e_idle("b2b_idle")); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({cw, k, ready, busy, fault} !== {e.cw, e.k, e.rdy, e.busy, e.flt}) begin
                bad++;
                $display("FAIL %s[%0d] got cw=%h k=%h rdy=%b busy=%b flt=%b want cw=%h k=%h rdy=%b busy=%b flt=%b",
                         e.name, n, cw, k, ready, busy, fault, e.cw, e.k, e.rdy, e.busy, e.flt);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        instr     = 32'd0;
        valid     = 1'b0;
        status    = 5'd0;
        mem_ready = 1'b0;
        test_reset();
        test_illegal();
        test_movk();
        test_ldur_wait();
        test_stur_timeout();
        test_stur_last_wait();
        test_branch();
        test_reset_in_movk2();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
